// File: rtl/poly1305_block_formatter.sv
// Formats AAD and payload byte beats into zero-padded 16-byte Poly1305 blocks, then appends the length block.
// Optional keep-contiguity checking is enabled by defining PFMT_KEEP_CHECK_EN.
module poly1305_block_formatter #(
    parameter int CNT_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         aad_valid,
    input  logic [127:0] aad_data,
    input  logic [15:0]  aad_keep,
    input  logic         aad_last,
    output logic         aad_ready,
    input  logic         pld_valid,
    input  logic [127:0] pld_data,
    input  logic [15:0]  pld_keep,
    input  logic         pld_last,
    output logic         pld_ready,
    output logic         blk_valid,
    output logic [127:0] blk_data,
    output logic [1:0]   blk_kind,
    input  logic         blk_ready,
    output logic         busy,
    output logic         done,
    output logic         err_keep
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_PLD,
        S_LEN,
        S_WAIT_LEN,
        S_DONE
    } state_t;

    localparam logic [1:0] KIND_AAD = 2'd0;
    localparam logic [1:0] KIND_PLD = 2'd1;
    localparam logic [1:0] KIND_LEN = 2'd2;

    state_t             state, state_next;
    logic               slot_free;
    logic               aad_fire, pld_fire;
    logic [127:0]       beat_data;
    logic [15:0]        beat_keep;
    logic               load_beat, load_len, clr_msg, done_next;
    logic [CNT_W-1:0]   aad_cnt, pld_cnt;

    function automatic logic [4:0] popcount16(input logic [15:0] k);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) n = n + 5'(k[i]);
        return n;
    endfunction

    function automatic logic [127:0] byte_mask(input logic [15:0] k);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // The output register is free when empty or being drained this cycle.
    assign slot_free = !blk_valid || blk_ready;
    assign aad_ready = (state == S_AAD) && slot_free;
    assign pld_ready = (state == S_PLD) && slot_free;
    assign aad_fire  = aad_valid && aad_ready;
    assign pld_fire  = pld_valid && pld_ready;
    assign beat_data = pld_fire ? pld_data : aad_data;
    assign beat_keep = pld_fire ? pld_keep : aad_keep;
    assign busy      = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        load_beat  = 1'b0;
        load_len   = 1'b0;
        clr_msg    = 1'b0;
        done_next  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clr_msg    = 1'b1;
                    state_next = S_AAD;
                end
            end
            S_AAD: begin
                if (aad_fire) begin
                    load_beat = |aad_keep;
                    if (aad_last) state_next = S_PLD;
                end
            end
            S_PLD: begin
                if (pld_fire) begin
                    load_beat = |pld_keep;
                    if (pld_last) state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (slot_free) begin
                    load_len   = 1'b1;
                    state_next = S_WAIT_LEN;
                end
            end
            S_WAIT_LEN: begin
                // blk_valid is always set here: the length block was loaded on entry.
                if (blk_ready) begin
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_kind  <= KIND_AAD;
            aad_cnt   <= '0;
            pld_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_next;
            if (load_beat) begin
                blk_valid <= 1'b1;
                blk_data  <= beat_data & byte_mask(beat_keep);
                blk_kind  <= pld_fire ? KIND_PLD : KIND_AAD;
            end else if (load_len) begin
                blk_valid <= 1'b1;
                blk_data  <= {64'(pld_cnt), 64'(aad_cnt)};
                blk_kind  <= KIND_LEN;
            end else if (blk_ready) begin
                blk_valid <= 1'b0;
            end

            if (clr_msg) begin
                aad_cnt <= '0;
                pld_cnt <= '0;
            end else begin
                if (aad_fire) aad_cnt <= aad_cnt + CNT_W'(popcount16(aad_keep));
                if (pld_fire) pld_cnt <= pld_cnt + CNT_W'(popcount16(pld_keep));
            end
        end
    end

`ifdef PFMT_KEEP_CHECK_EN
    logic keep_bad;

    // Contiguous LSB masks have no set bit above a clear one: k & (k+1) == 0.
    assign keep_bad = |(beat_keep & (beat_keep + 16'd1));

    always_ff @(posedge clk) begin
        if (rst)                                     err_keep <= 1'b0;
        else if (clr_msg)                            err_keep <= 1'b0;
        else if ((aad_fire || pld_fire) && keep_bad) err_keep <= 1'b1;
    end
`else
    assign err_keep = 1'b0;
`endif

endmodule

// File: tb/tb_poly1305_block_formatter.sv
// Directed self-checking bench for poly1305_block_formatter; a second instance with CNT_W=4 checks counter wrap.
module tb_poly1305_block_formatter;

`ifdef PFMT_KEEP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam logic [127:0] A1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] P1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] P2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] P3 = 128'h55AA55AA_66BB66BB_77CC77CC_88DD88DD;
    localparam logic [127:0] DX = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    logic         clk = 1'b0;
    logic         rst, start;
    logic         aad_valid, aad_last, pld_valid, pld_last, blk_ready;
    logic [127:0] aad_data, pld_data;
    logic [15:0]  aad_keep, pld_keep;
    logic         aad_ready, pld_ready, blk_valid, busy, done, err_keep;
    logic [127:0] blk_data;
    logic [1:0]   blk_kind;
    logic         aad_ready4, pld_ready4, blk_valid4, busy4, done4, err_keep4;
    logic [127:0] blk_data4;
    logic [1:0]   blk_kind4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    poly1305_block_formatter u_dut (
        .clk(clk), .rst(rst), .start(start),
        .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_last(aad_last),
        .aad_ready(aad_ready),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_last(pld_last),
        .pld_ready(pld_ready),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_kind(blk_kind), .blk_ready(blk_ready),
        .busy(busy), .done(done), .err_keep(err_keep)
    );

    poly1305_block_formatter #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start),
        .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_last(aad_last),
        .aad_ready(aad_ready4),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_last(pld_last),
        .pld_ready(pld_ready4),
        .blk_valid(blk_valid4), .blk_data(blk_data4), .blk_kind(blk_kind4), .blk_ready(blk_ready),
        .busy(busy4), .done(done4), .err_keep(err_keep4)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_blk(input string tag, input logic [127:0] data, input logic [1:0] kind);
        check({tag, "_valid"}, blk_valid, 1'b1);
        check({tag, "_data"}, blk_data, data);
        check({tag, "_kind"}, blk_kind, kind);
    endtask

    task automatic aad_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        aad_valid = 1'b1; aad_data = d; aad_keep = k; aad_last = l;
        tick();
        aad_valid = 1'b0; aad_last = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; blk_ready = 1'b1;
        aad_valid = 1'b0; aad_data = '0; aad_keep = '0; aad_last = 1'b0;
        pld_valid = 1'b0; pld_data = '0; pld_keep = '0; pld_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_blk_valid", blk_valid, 1'b0);
        check("rst_blk_data", blk_data, 128'd0);
        check("rst_blk_kind", blk_kind, 2'd0);
        check("rst_aad_ready", aad_ready, 1'b0);
        check("rst_pld_ready", pld_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err_keep", err_keep, 1'b0);

        // 1: full AAD beat, two full payload beats, length block, done pulse
        pulse_start();
        check("t1_aad_ready", aad_ready, 1'b1);
        check("t1_busy", busy, 1'b1);
        aad_beat(A1, 16'hFFFF, 1'b1);
        expect_blk("t1_blk0", A1, 2'd0);
        pld_valid = 1'b1; pld_data = P1; pld_keep = 16'hFFFF; pld_last = 1'b0;
        #1 check("t1_pld_ready", pld_ready, 1'b1);
        tick();
        expect_blk("t1_blk1", P1, 2'd1);
        pld_data = P2; pld_last = 1'b1;
        tick();
        pld_valid = 1'b0; pld_last = 1'b0;
        expect_blk("t1_blk2", P2, 2'd1);
        tick();
        expect_blk("t1_len", {64'd32, 64'd16}, 2'd2);
        check("t1_done_early", done, 1'b0);
        tick();
        check("t1_done", done, 1'b1);
        check("t1_idle_valid", blk_valid, 1'b0);
        check("t1_not_busy", busy, 1'b0);
        tick();
        check("t1_done_pulse", done, 1'b0);

        // 2: partial AAD with junk above keep, empty payload
        pulse_start();
        aad_beat(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFAABBCC, 16'h0007, 1'b1);
        expect_blk("t2_blk0", 128'hAABBCC, 2'd0);
        pld_valid = 1'b1; pld_data = P1; pld_keep = 16'h0000; pld_last = 1'b1;
        tick();
        pld_valid = 1'b0; pld_last = 1'b0;
        check("t2_no_pld_blk", blk_valid, 1'b0);
        tick();
        expect_blk("t2_len", {64'd0, 64'd3}, 2'd2);
        tick();
        check("t2_done", done, 1'b1);

        // 3: backpressure during payload, then full throughput
        pulse_start();
        aad_beat(A1, 16'h0000, 1'b1);
        check("t3_empty_aad", blk_valid, 1'b0);
        blk_ready = 1'b0;
        pld_valid = 1'b1; pld_data = P1; pld_keep = 16'hFFFF; pld_last = 1'b0;
        #1 check("t3_pld_ready0", pld_ready, 1'b1);
        tick();
        pld_data = P2;
        expect_blk("t3_p1", P1, 2'd1);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_ready", pld_ready, 1'b0);
            check("t3_stall_data", blk_data, P1);
            tick();
        end
        blk_ready = 1'b1;
        #1 check("t3_resume_ready", pld_ready, 1'b1);
        tick();
        expect_blk("t3_p2", P2, 2'd1);
        pld_data = P3; pld_last = 1'b1;
        tick();
        pld_valid = 1'b0; pld_last = 1'b0;
        expect_blk("t3_p3", P3, 2'd1);
        tick();
        expect_blk("t3_len", {64'd48, 64'd0}, 2'd2);
        tick();
        check("t3_done", done, 1'b1);

        // 4: reset while a payload block is held
        pulse_start();
        aad_beat(A1, 16'hFFFF, 1'b1);
        pld_valid = 1'b1; pld_data = P1; pld_keep = 16'hFFFF; pld_last = 1'b0;
        tick();
        expect_blk("t4_held", P1, 2'd1);
        rst = 1'b1; blk_ready = 1'b0; pld_valid = 1'b0;
        tick();
        rst = 1'b0; blk_ready = 1'b1;
        check("t4_rst_valid", blk_valid, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_data", blk_data, 128'd0);
        #1 check("t4_rst_aad_ready", aad_ready, 1'b0);
        pulse_start();
        aad_beat(DX, 16'h000F, 1'b1);
        expect_blk("t4_aad", 128'h76543210, 2'd0);
        pld_valid = 1'b1; pld_data = DX; pld_keep = 16'h00FF; pld_last = 1'b1;
        tick();
        pld_valid = 1'b0; pld_last = 1'b0;
        expect_blk("t4_pld", 128'hFEDCBA9876543210, 2'd1);
        tick();
        expect_blk("t4_len", {64'd8, 64'd4}, 2'd2);
        tick();
        check("t4_done", done, 1'b1);

        // 5: non-contiguous keep
        pulse_start();
        aad_beat(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FF332211, 16'h0005, 1'b1);
        expect_blk("t5_aad", 128'h330011, 2'd0);
        check("t5_err", err_keep, EXP_ERR);
        pld_valid = 1'b1; pld_keep = 16'h0000; pld_last = 1'b1;
        tick();
        pld_valid = 1'b0; pld_last = 1'b0;
        tick();
        expect_blk("t5_len", {64'd0, 64'd2}, 2'd2);
        check("t5_err_sticky", err_keep, EXP_ERR);
        tick();
        check("t5_done", done, 1'b1);
        pulse_start();
        check("t5_err_cleared", err_keep, 1'b0);

        // 6: 17 AAD bytes; the CNT_W=4 instance wraps to 1
        aad_beat(A1, 16'hFFFF, 1'b0);
        expect_blk("t6_a0", A1, 2'd0);
        aad_beat(128'hEE, 16'h0001, 1'b1);
        expect_blk("t6_a1", 128'hEE, 2'd0);
        pld_valid = 1'b1; pld_keep = 16'h0000; pld_last = 1'b1;
        tick();
        pld_valid = 1'b0; pld_last = 1'b0;
        tick();
        expect_blk("t6_len64", {64'd0, 64'd17}, 2'd2);
        check("t6_len4_valid", blk_valid4, 1'b1);
        check("t6_len4_data", blk_data4, {64'd0, 64'd1});
        check("t6_len4_kind", blk_kind4, 2'd2);
        tick();
        check("t6_done", done, 1'b1);
        check("t6_done4", done4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
